// File: rtl/cpu_pkg.sv
// Shared CPU constants and the RAM load controller state type.
package cpu_pkg;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MAN_IDLE = 2'd1,
    WRITE    = 2'd2,
    CLEAR    = 2'd3
  } ram_load_state_t;

endpackage

// File: rtl/ram_load_controller_if.sv
// CPU-side request bus in, program RAM port out.
interface ram_load_controller_if #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    input  cpu_addr, cpu_we, cpu_wdata,
    output ram_addr, ram_we, ram_wdata
  );

  modport slave (
    output cpu_addr, cpu_we, cpu_wdata,
    input  ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/panel_input_sync.sv
// Synchroniser for one asynchronous panel input: level output plus a
// registered one-cycle pulse on each synchronised rising edge.
module panel_input_sync #(
  parameter int SYNC_STAGES = cpu_pkg::SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign pulse = pulse_q;

endmodule

// File: rtl/ram_load_controller.sv
// Arbitrates the program RAM port between the CPU and the front-panel loader.
//   state    | meaning
//   RUN      | CPU owns the RAM port, panel buttons ignored
//   MAN_IDLE | CPU held, RAM addressed by load_addr, waiting for a button
//   WRITE    | one-cycle write of captured switch data at load_addr
//   CLEAR    | zero every RAM word, one per cycle
module ram_load_controller
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int SYNC_STAGES = cpu_pkg::SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  manual_mode,
  input  logic                  write_btn,
  input  logic                  next_btn,
  input  logic                  clear_btn,
  input  logic [DATA_W-1:0]     program_switches,
  ram_load_controller_if.master bus,
  output logic [ADDR_W-1:0]     load_addr,
  output logic                  cpu_hold,
  output logic                  busy
);

  logic man_lvl, man_pulse_unused;
  logic wr_lvl_unused, wr_p;
  logic nxt_lvl_unused, nxt_p;
  logic clr_lvl_unused, clr_p;

  panel_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_man (
    .clk(clk), .rst_n(rst_n), .async_in(manual_mode),
    .level(man_lvl), .pulse(man_pulse_unused)
  );
  panel_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst_n(rst_n), .async_in(write_btn),
    .level(wr_lvl_unused), .pulse(wr_p)
  );
  panel_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nxt (
    .clk(clk), .rst_n(rst_n), .async_in(next_btn),
    .level(nxt_lvl_unused), .pulse(nxt_p)
  );
  panel_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .rst_n(rst_n), .async_in(clear_btn),
    .level(clr_lvl_unused), .pulse(clr_p)
  );

  ram_load_state_t   state_q, state_d;
  logic [ADDR_W-1:0] load_q, load_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      RUN: begin
        if (man_lvl) state_d = MAN_IDLE;
      end
      MAN_IDLE: begin
        if (clr_p) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (wr_p) begin
          data_d  = program_switches;
          state_d = WRITE;
        end else if (nxt_p) begin
          load_d = load_q + ADDR_W'(1);
        end else if (!man_lvl) begin
          state_d = RUN;
        end
      end
      WRITE: begin
        load_d  = load_q + ADDR_W'(1);
        state_d = MAN_IDLE;
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          load_d  = '0;
          state_d = MAN_IDLE;
        end
      end
      default: state_d = RUN;
    endcase
    // Status flags are registered from the next state so they line up with it.
    hold_d = (state_d != RUN);
    busy_d = (state_d == WRITE) || (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      load_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_we    = bus.cpu_we;
    bus.ram_wdata = bus.cpu_wdata;
    unique case (state_q)
      RUN: ;
      CLEAR: begin
        bus.ram_addr  = cnt_q;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = '0;
      end
      WRITE: begin
        bus.ram_addr  = load_q;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = data_q;
      end
      default: begin
        bus.ram_addr  = load_q;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = data_q;
      end
    endcase
  end

  assign load_addr = load_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_load_controller.sv
// Directed plus randomized bench for ram_load_controller with a behavioural RAM/loader model.
module tb_ram_load_controller;
  import cpu_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int DW    = DATA_W;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          manual_mode = 1'b0;
  logic          write_btn = 1'b0;
  logic          next_btn = 1'b0;
  logic          clear_btn = 1'b0;
  logic [DW-1:0] program_switches = '0;
  logic [AW-1:0] load_addr;
  logic          cpu_hold;
  logic          busy;

  ram_load_controller_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_load_controller dut (
    .clk(clk), .rst_n(rst_n), .manual_mode(manual_mode),
    .write_btn(write_btn), .next_btn(next_btn), .clear_btn(clear_btn),
    .program_switches(program_switches), .bus(bus),
    .load_addr(load_addr), .cpu_hold(cpu_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM the controller drives, plus a log of every write it sees
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int            exp_load = 0;
  int            we_cnt = 0, busy_cnt = 0, cyc = 0;
  int            log_addr[$], log_data[$], log_cyc[$];
  int            n_pass = 0, n_fail = 0, n_total = 0;

  always @(posedge clk) begin
    cyc++;
    if (bus.ram_we === 1'b1) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
      we_cnt++;
      log_addr.push_back(int'(bus.ram_addr));
      log_data.push_back(int'(bus.ram_wdata));
      log_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    we_cnt = 0; busy_cnt = 0;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic do_write(logic [DW-1:0] d);
    int w0;
    w0 = we_cnt;
    program_switches = d;
    write_btn = 1'b1;
    tick(3);
    check("wr_latency_early", bus.ram_we, 0);
    tick(1);
    check("wr_we", bus.ram_we, 1);
    check("wr_addr", bus.ram_addr, exp_load);
    check("wr_data", bus.ram_wdata, d);
    check("wr_busy", busy, 1);
    check("wr_hold", cpu_hold, 1);
    program_switches = DW'($urandom);
    tick(1);
    check("wr_one_cycle", bus.ram_we, 0);
    tick(2);
    write_btn = 1'b0;
    tick(4);
    check("wr_count", we_cnt - w0, 1);
    exp_mem[exp_load] = d;
    exp_load = (exp_load + 1) % DEPTH;
    check("wr_load_addr", load_addr, exp_load);
  endtask

  task automatic do_next();
    next_btn = 1'b1;
    tick(5);
    next_btn = 1'b0;
    tick(4);
    exp_load = (exp_load + 1) % DEPTH;
  endtask

  // Expect exactly one full clear sweep in the log: addresses 0..DEPTH-1 on consecutive cycles, data 0
  task automatic verify_clear(string tag);
    bit ok;
    ok = (log_addr.size() == DEPTH);
    if (ok)
      for (int i = 0; i < DEPTH; i++)
        if (log_addr[i] != i || log_data[i] != 0 || log_cyc[i] != log_cyc[0] + i) ok = 0;
    check({tag, "_sweep"}, ok, 1);
    check({tag, "_we_count"}, we_cnt, DEPTH);
    ok = 1;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== '0) ok = 0;
    check({tag, "_ram_zero"}, ok, 1);
    check({tag, "_load_addr"}, load_addr, 0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    exp_load = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    bus.cpu_addr = 4'd5; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h3C;
    tick(2);
    check("rst_ram_addr", bus.ram_addr, 5);
    check("rst_ram_we", bus.ram_we, 1);
    check("rst_ram_wdata", bus.ram_wdata, 8'h3C);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_load_addr", load_addr, 0);
    rst_n = 1'b1;
    tick(3);

    // RUN: transparent CPU path
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr = AW'($urandom); bus.cpu_we = 1'($urandom); bus.cpu_wdata = DW'($urandom);
      #1;
      check("run_addr", bus.ram_addr, bus.cpu_addr);
      check("run_we", bus.ram_we, bus.cpu_we);
      check("run_wdata", bus.ram_wdata, bus.cpu_wdata);
      tick(1);
    end
    bus.cpu_we = 1'b0;
    clear_log();
    write_btn = 1'b1; tick(3); write_btn = 1'b0;
    next_btn = 1'b1; tick(3); next_btn = 1'b0; tick(5);
    check("run_btn_ignored_we", we_cnt, 0);
    check("run_btn_ignored_load", load_addr, 0);
    check("run_no_hold", cpu_hold, 0);

    // Enter programming mode; CPU write requests must be masked
    bus.cpu_addr = 4'd9; bus.cpu_we = 1'b1;
    manual_mode = 1'b1;
    tick(4);
    check("man_hold", cpu_hold, 1);
    check("man_cpu_we_masked", bus.ram_we, 0);
    check("man_addr_is_load", bus.ram_addr, 0);
    bus.cpu_we = 1'b0;

    do_write(8'hA7);
    do_write(8'h11);
    check("ram0", ram[0], 8'hA7);
    check("ram1", ram[1], 8'h11);
    check("load_after_two", load_addr, 2);

    // Skip with wrap
    clear_log();
    repeat (14) do_next();
    check("next_wrap_to_0", load_addr, 0);
    repeat (17) do_next();
    check("next17_load", load_addr, 1);
    check("next_no_write", we_cnt, 0);
    check("next_hold", cpu_hold, 1);
    do_write(8'hFF);
    check("ram1_ff", ram[1], 8'hFF);

    // Clear-all over nonzero contents
    clear_log();
    clear_btn = 1'b1;
    tick(3);
    check("clr_latency_early", bus.ram_we, 0);
    tick(1);
    check("clr_first_we", bus.ram_we, 1);
    check("clr_first_addr", bus.ram_addr, 0);
    check("clr_first_data", bus.ram_wdata, 0);
    tick(2);
    clear_btn = 1'b0;
    tick(20);
    verify_clear("clr");
    check("clr_busy_cycles", busy_cnt, DEPTH);

    // Random writes and skips against the model
    repeat (24) begin
      if ($urandom_range(0, 3) == 3) do_next();
      else do_write(DW'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) check($sformatf("rand_ram%0d", i), ram[i], exp_mem[i]);
    check("rand_load", load_addr, exp_load);

    // Clear and write together: clear wins
    clear_log();
    program_switches = 8'h5A;
    clear_btn = 1'b1; write_btn = 1'b1;
    tick(6);
    clear_btn = 1'b0; write_btn = 1'b0;
    tick(22);
    verify_clear("clr_wr_same");

    // Write pressed during a clear is dropped
    do_next(); do_next();
    clear_log();
    clear_btn = 1'b1; tick(6); clear_btn = 1'b0;
    write_btn = 1'b1; tick(3); write_btn = 1'b0;
    tick(22);
    verify_clear("clr_wr_drop");

    // Leaving programming mode mid-clear finishes the sweep first
    clear_log();
    bus.cpu_addr = 4'd7; bus.cpu_wdata = 8'h99;
    clear_btn = 1'b1; tick(4); clear_btn = 1'b0;
    tick(6);
    manual_mode = 1'b0;
    tick(3);
    check("drop_busy_mid", busy, 1);
    check("drop_hold_mid", cpu_hold, 1);
    tick(15);
    verify_clear("clr_drop");
    check("drop_run_hold", cpu_hold, 0);
    check("drop_run_addr", bus.ram_addr, 7);
    check("drop_run_wdata", bus.ram_wdata, 8'h99);

    // Reset in the middle of a clear
    manual_mode = 1'b1;
    tick(4);
    do_next(); do_next();
    check("pre_rst_load", load_addr, 2);
    clear_log();
    clear_btn = 1'b1;
    tick(8);
    check("pre_rst_busy", busy, 1);
    bus.cpu_addr = 4'd3; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h42;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_load", load_addr, 0);
    check("mid_rst_addr", bus.ram_addr, 3);
    check("mid_rst_we", bus.ram_we, 1);
    check("mid_rst_wdata", bus.ram_wdata, 8'h42);
    clear_btn = 1'b0; manual_mode = 1'b0; bus.cpu_we = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("post_rst_no_pulse", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_load_controller.md
Name: ram_load_controller

Overview:
Owns the 16x8 program RAM's address, write-data and write-enable inputs, and arbitrates them between the CPU datapath (run mode) and the front-panel programming controls (manual mode).
- In manual mode it holds the CPU and maintains an auto-incrementing load address.
- It turns debounced panel button presses into single-cycle RAM writes.
- It provides a sequenced clear-all that zeroes every RAM word.
- It sits between the control unit/MAR and the RAM, next to the panel switch inputs.

Parameters:
ADDR_W, 4, RAM address width (depth = 2**ADDR_W)
DATA_W, 8, RAM word width
SYNC_STAGES, 2, flops in each panel-input synchroniser (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous, active-low
manual_mode  in  1  panel run/program switch, asynchronous level (1 = program)
write_btn  in  1  panel write button, asynchronous, pre-debounced
next_btn  in  1  panel skip button: advance address without writing
clear_btn  in  1  panel clear-all button
program_switches  in  DATA_W  panel data switches
cpu_addr  in  ADDR_W  MAR address from datapath
cpu_we  in  1  RAM write request from control unit
cpu_wdata  in  DATA_W  bus data from datapath
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable, sampled by RAM on posedge clk
ram_wdata  out  DATA_W  RAM write data
load_addr  out  ADDR_W  current programming address, for the panel LEDs
cpu_hold  out  1  stalls the CPU clock enable while not in RUN
busy  out  1  high during WRITE or CLEAR

Behaviour:
- All panel inputs pass through SYNC_STAGES-flop synchronisers. Buttons are rising-edge detected on the synchronised value, giving a 1-cycle pulse.
- FSM states: RUN, MAN_IDLE, WRITE, CLEAR. State is registered.
- Reset values:
  - state = RUN; load_addr = 0; clear counter = 0; data capture register = 0.
  - cpu_hold = 0; busy = 0.
  - ram_addr, ram_we and ram_wdata follow cpu_addr, cpu_we and cpu_wdata.
  - Synchroniser and edge flops = 0, so no spurious pulse is produced after reset.
- RUN:
  - ram_* = cpu_* (combinational mux); cpu_hold = 0.
  - Button pulses are ignored.
  - Synchronised manual_mode = 1 -> MAN_IDLE next cycle.
- Every state other than RUN: cpu_hold = 1. ram_we is driven by the FSM only; cpu_we is ignored.
- MAN_IDLE:
  - ram_addr = load_addr; ram_we = 0.
  - Pulse priority: clear > write > next. Only one action is taken per cycle.
  - clear pulse -> CLEAR, clear counter = 0.
  - write pulse -> capture program_switches into the data register that cycle, then go to WRITE.
  - next pulse -> load_addr + 1 (wraps 15 -> 0); stay in MAN_IDLE.
  - Synchronised manual_mode = 0 with no pulse -> RUN. load_addr is retained.
- WRITE:
  - Lasts exactly 1 cycle. ram_we = 1, ram_addr = load_addr, ram_wdata = captured data.
  - On exit, load_addr increments (wraps 15 -> 0). Next state is MAN_IDLE.
- CLEAR:
  - Lasts exactly 2**ADDR_W cycles. ram_we = 1, ram_addr = counter, ram_wdata = 0.
  - Counter increments each cycle. When counter = max: load_addr = 0, go to MAN_IDLE.
- Button pulses arriving in WRITE or CLEAR are dropped, not queued.
- manual_mode falling during WRITE or CLEAR: the operation completes first, then MAN_IDLE exits to RUN on the following cycle.
- Latency: a button sampled high at edge k produces ram_we high in the cycle starting at edge k+SYNC_STAGES+1.
- Holding a button produces exactly one action; it must be released and pressed again for another.
- Write data is the switch value captured at the pulse. Later switch changes do not affect that write.
- Reset asserted mid-WRITE or mid-CLEAR: immediate return to RUN with outputs at reset values. A partial clear is acceptable.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants.
  - typedef enum logic [1:0] ram_load_state_t {RUN, MAN_IDLE, WRITE, CLEAR}.
- One sub-module, panel_input_sync: SYNC_STAGES synchroniser producing a level output plus a rising-edge pulse.
  - Instanced for manual_mode (level output used).
  - Instanced for each of the three buttons (pulse output used).
- The program_switches bus is sampled only at a write pulse, so a data synchroniser is not required.

Test Plan:
- Reset, manual_mode = 0, cpu_addr = 5, cpu_we = 1, cpu_wdata = 0x3C -> ram_addr = 5, ram_we = 1, ram_wdata = 0x3C, cpu_hold = 0, load_addr = 0.
- manual_mode = 1; switches = 0xA7; press write; then switches = 0x11; press write -> RAM[0] = 0xA7, RAM[1] = 0x11, load_addr = 2, each ram_we exactly 1 cycle, cpu_hold = 1 throughout.
- Press next 17 times from load_addr 0 -> load_addr = 1, no ram_we pulse; then write 0xFF -> RAM[1] = 0xFF.
- Preload RAM with nonzero data; press clear -> ram_we high 16 consecutive cycles, addresses 0..15, data 0; busy for 16 cycles; RAM all zero; load_addr = 0.
- clear and write pressed the same cycle -> CLEAR only. Write pressed during CLEAR -> dropped. manual_mode dropped mid-CLEAR -> all 16 writes complete, then RUN, cpu_hold = 0.
- Assert rst_n = 0 at cycle 5 of CLEAR -> state RUN immediately, busy = 0, load_addr = 0, ram_* follow cpu_*.
